output_holder: RTL
==================

// Module: output_holder
// PURPOSE
//  Downstream stage of the stream-cipher encryption block. Captures each pulsed encrypted byte into a
//  small FIFO so no ciphertext is lost while the consumer (output pins / serializer) is stalled.
//  Drains bytes to the consumer over a valid/ready handshake. Reports fill state, and flags
//  overflow when a byte arrives with the FIFO full and nothing leaving.
// PARAMETERS
//  DEPTH   4              number of byte entries; power of two, >= 2
//  ADDR_W  $clog2(DEPTH)  pointer width (derived; do not override)
// PORTS
//  clk                     in   1         system clock; all logic on posedge
//  rst                     in   1         synchronous, active-high reset
//  encrypted_byte_in       in   8         ciphertext byte from encryption block
//  encrypted_byte_pulse_in in   1         1-cycle strobe: encrypted_byte_in valid this cycle
//  byte_out                out  8         head-of-FIFO byte; 8'h00 when empty
//  byte_valid_out          out  1         FIFO non-empty; byte_out is valid
//  byte_ready_in           in   1         consumer accepts byte_out this cycle
//  count_out               out  ADDR_W+1  entries held, 0..DEPTH
//  full_out                out  1         count_out == DEPTH
//  empty_out               out  1         count_out == 0
//  overflow_out            out  1         sticky: at least one byte was dropped
//  clear_overflow_in       in   1         clears overflow_out
//  output_holder_state_out out  enum      EMPTY / HOLDING / FULL
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, overflow=0, state=EMPTY.
//    Hence byte_out=0, byte_valid_out=0, empty_out=1, full_out=0. Storage array is not reset.
//    A reset mid-operation discards all held bytes. Reset has priority over every other input.
//  - Push: encrypted_byte_pulse_in=1 and (count<DEPTH or pop this cycle) -> mem[wr_ptr]<=byte;
//    wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
//  - Pop: byte_valid_out && byte_ready_in -> rd_ptr increments modulo DEPTH.
//    byte_ready_in while empty has no effect.
//  - Show-ahead output: byte_out = mem[rd_ptr] combinationally when count>0, else 8'h00.
//  - Latency: a byte pushed at edge N into an empty FIFO gives byte_valid_out=1 after edge N.
//    Same-cycle bypass of input to output is not permitted.
//  - Count update: push only +1; pop only -1; push and pop together leaves count unchanged.
//    Simultaneous push+pop when full is legal: both happen and the FIFO stays FULL.
//    Simultaneous push+pop when empty cannot occur (no pop when empty); push only.
//  - Overflow: pulse with count==DEPTH and no pop -> byte dropped; pointers and count unchanged;
//    overflow set at next edge. overflow holds until clear_overflow_in=1.
//    A drop in the same cycle as the clear wins: overflow stays 1.
//  - FSM (registered; outputs decoded from state):
//      EMPTY   -> HOLDING on push
//      HOLDING -> FULL when count becomes DEPTH
//      HOLDING -> EMPTY when count becomes 0
//      FULL    -> HOLDING on pop without push
//    State must always equal the decode of count; the bench asserts this every cycle.
//  - count_out, full_out, empty_out, overflow_out are registered-derived; no comb path from inputs.
//    Only byte_out depends combinationally on rd_ptr/mem.
// STRUCTURE
//  - output_holder_state_t {EMPTY, HOLDING, FULL} lives in shared package stream_cipher_pkg,
//    alongside encryption_block_state_t and hash_generator_state_t.
//  - Storage plus pointers go in one sub-module, byte_fifo (DEPTH param; push/pop/count I/F).
//    output_holder wraps byte_fifo and adds the FSM, overflow tracking and port mapping.
//  - 3-block style: state register, next-state/next-value comb block, output assigns.
// TESTING
//  1 Reset: rst=1 two cycles -> byte_out=00, valid=0, empty=1, count=0, state=EMPTY, overflow=0.
//  2 Single pass: pulse A5, ready=1 -> valid=1 with byte_out=A5 next cycle; popped; back to EMPTY.
//  3 Fill/overflow, DEPTH=4, ready=0: pulse 01,02,03,04 -> full=1, FULL.
//    Pulse 05 -> overflow=1, count=4. Drain -> 01,02,03,04 in order (05 never appears).
//  4 Full with simultaneous push+pop: 4 held, pulse 10 while ready=1 -> count stays 4, no overflow.
//    Drained order ends ...,04,10.
//  5 Wrap: 10 push/pop pairs of 0x30+i with random ready stalls -> output order exact.
//    Pointers wrap at least twice; count never exceeds 4.
//  6 Reset mid-op: 3 bytes held, rst=1 one cycle -> count=0, valid=0.
//    Next pulse 7E emerges as the first byte. Clear overflow during a drop -> overflow stays 1.

Source files
------------

// File: rtl/stream_cipher_pkg.sv
// rtl/stream_cipher_pkg.sv - shared state types for the stream-cipher datapath
package stream_cipher_pkg;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_KEYING,
    ENC_RUNNING
  } encryption_block_state_t;

  typedef enum logic [1:0] {
    HASH_IDLE,
    HASH_ABSORB,
    HASH_SQUEEZE
  } hash_generator_state_t;

  typedef enum logic [1:0] {
    EMPTY,
    HOLDING,
    FULL
  } output_holder_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte storage with wrapping pointers and occupancy count
module byte_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_in,
  input  logic [7:0]        data_in,
  input  logic              pop_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W:0]   count_out
);

  logic [7:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  // push_in/pop_in arrive already qualified by the wrapper; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_in) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_in)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_in, pop_in})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_in) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign count_out = count_q;

endmodule

// File: rtl/output_holder.sv
// rtl/output_holder.sv - ciphertext holding FIFO with fill-state FSM and sticky overflow
module output_holder
  import stream_cipher_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           encrypted_byte_in,
  input  logic                 encrypted_byte_pulse_in,
  output logic [7:0]           byte_out,
  output logic                 byte_valid_out,
  input  logic                 byte_ready_in,
  output logic [ADDR_W:0]      count_out,
  output logic                 full_out,
  output logic                 empty_out,
  output logic                 overflow_out,
  input  logic                 clear_overflow_in,
  output output_holder_state_t output_holder_state_out
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  output_holder_state_t state_q, state_d;
  logic                 overflow_q, overflow_d;
  logic                 push_ok, pop_ok, drop;
  logic [ADDR_W:0]      count;

  byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_in   (push_ok),
    .data_in   (encrypted_byte_in),
    .pop_in    (pop_ok),
    .data_out  (byte_out),
    .count_out (count)
  );

  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign pop_ok  = (state_q != EMPTY) && byte_ready_in;
  assign push_ok = encrypted_byte_pulse_in && ((state_q != FULL) || pop_ok);
  assign drop    = encrypted_byte_pulse_in && (state_q == FULL) && !pop_ok;

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    case (state_q)
      EMPTY:   if (push_ok) state_d = HOLDING;
      HOLDING: begin
        if (push_ok && !pop_ok && count == LAST_CNT)       state_d = FULL;
        else if (pop_ok && !push_ok && count == 1'b1)      state_d = EMPTY;
      end
      FULL:    if (pop_ok && !push_ok) state_d = HOLDING;
      default: state_d = EMPTY;
    endcase
    if (drop)                   overflow_d = 1'b1;
    else if (clear_overflow_in) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign byte_valid_out          = (state_q != EMPTY);
  assign empty_out               = (state_q == EMPTY);
  assign full_out                = (state_q == FULL);
  assign count_out               = count;
  assign overflow_out            = overflow_q;
  assign output_holder_state_out = state_q;

endmodule
